race_requester: RTL and testbench
=================================

RACE_REQUESTER -- requirements
Module: race_requester

Interface
REQ-001 Parameter NUM_W, default 8, SHALL set the width of the request-count command.
REQ-002 Parameter LAT_W, default 16, SHALL set the width of the latency counter and latency outputs.
REQ-003 Parameter TIMEOUT, default 1024, SHALL set the maximum number of cycles one request waits for done.
REQ-004 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, asynchronous, active-low.
REQ-006 go  input  1  SHALL be a one-cycle command pulse that starts a batch.
REQ-007 num_req  input  NUM_W  SHALL be the number of requests in the batch, sampled when go is accepted.
REQ-008 start  output  1  SHALL be the request level driven to the downstream responder.
REQ-009 done  input  1  SHALL be the completion pulse returned by the responder.
REQ-010 busy  output  1  SHALL be high while a batch is in progress.
REQ-011 finished  output  1  SHALL be a one-cycle pulse when a batch ends, whether by completion or by timeout.
REQ-012 timeout_err  output  1  SHALL be a sticky flag that one request exceeded TIMEOUT.
REQ-013 req_count  output  NUM_W  SHALL be the number of requests completed in the current or last batch.
REQ-014 last_latency / max_latency  output  LAT_W each  SHALL be the latency of the latest request and the maximum latency in the batch.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, GAP and FIN, all registered.
- IDLE: go=1 with num_req>0 -> REQ. At that edge the block SHALL latch num_req and clear req_count, max_latency, last_latency and timeout_err.
- IDLE: go=1 with num_req=0 -> FIN. No start is issued.
REQ-016 In REQ, start SHALL be 1 and the latency counter SHALL increment once per cycle in which done=0.
REQ-017 Latency SHALL be the number of rising edges from the edge that raised start up to and including the edge that first samples done=1; a done sampled at the first edge after start rises gives latency 1.
REQ-018 When REQ samples done=1, the block SHALL act at that edge:
- drop start;
- load last_latency;
- update max_latency = max(max_latency, latency);
- increment req_count;
- go to GAP.
REQ-019 GAP SHALL hold start=0 for exactly one cycle, so the responder cannot re-trigger.
REQ-020 GAP SHALL go to REQ if req_count < the latched num_req, otherwise to FIN.
REQ-021 FIN SHALL assert finished for exactly one cycle and then go to IDLE.
REQ-022 busy SHALL be 1 in REQ, GAP and FIN, and 0 in IDLE.
REQ-023 If the latency counter reaches TIMEOUT in REQ without done, the block SHALL drop start, set timeout_err, skip the remaining requests and go to FIN.
REQ-024 The latency counter SHALL saturate at all-ones and never wrap.
REQ-025 done sampled outside REQ SHALL be ignored and SHALL change no output.
REQ-026 go sampled while busy=1 SHALL be ignored.
REQ-027 If done=1 and the TIMEOUT limit occur on the same edge, done SHALL win and the request SHALL count as complete.

Reset
REQ-028 While rst=0, all of the following SHALL be held at 0: start, busy, finished, timeout_err, req_count, last_latency, max_latency and the latency counter.
REQ-029 While rst=0, the FSM SHALL be held in IDLE.
REQ-030 Reset asserted mid-batch SHALL abort the batch without a finished pulse.
REQ-031 After reset deasserts, the block SHALL accept go on the first clock edge.

Structure
REQ-032 A shared package/header race_pkg SHALL hold the FSM state encodings (2-bit) and the default values of LAT_W and TIMEOUT, shared with the downstream observer bench.
REQ-033 The latency counter (clear, enable, saturate, terminal-count flag) SHALL be one sub-module, race_lat_counter.
REQ-034 All other logic SHALL stay in race_requester.

Verification
REQ-035 Single request: go with num_req=1, bench responder returns done 3 edges after start rises -> start high 3 cycles, last_latency=3, req_count=1, one finished pulse, busy low after.
REQ-036 Batch: num_req=4, done latencies 1, 5, 2, 7 -> exactly one low GAP cycle between requests, req_count=4, max_latency=7, last_latency=7.
REQ-037 Timeout: TIMEOUT=16, responder never answers -> start drops after 16 cycles, timeout_err=1, req_count=0, finished pulse.
REQ-038 Zero and ignored commands: go with num_req=0 -> finished 1 cycle later, start never rises; a second go while busy -> no effect on req_count or num_req.
REQ-039 Reset mid-request at latency 2 of 3 -> all outputs 0 immediately, no finished pulse; a new go after reset runs normally.
REQ-040 Spurious done in IDLE and in GAP -> all outputs unchanged.

Source files
------------

// File: rtl/race_pkg.sv
// Shared encodings and default sizing for the request/latency racer and its downstream observer.
package race_pkg;

  localparam int LAT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/race_lat_counter.sv
// Per-request latency counter: clears outside a request, counts waiting cycles, saturates at all-ones.
// o_lat is the latency this edge would report; o_tc flags that this edge reaches the timeout limit.
module race_lat_counter #(
  parameter int          W     = 16,
  parameter int unsigned LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_lat,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = &r_cnt;
  assign o_lat = w_sat ? r_cnt : r_cnt + 1'b1;
  assign o_tc  = (32'(o_lat) >= LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_lat;
    end
  end

endmodule

// File: rtl/race_requester.sv
// Issues a batch of start/done handshakes, measuring per-request latency and aborting a batch on timeout.
// One idle GAP cycle separates requests; go is ignored while busy, done is ignored outside REQ.
module race_requester
  import race_pkg::*;
#(
  parameter int NUM_W   = 8,
  parameter int LAT_W   = LAT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [NUM_W-1:0] num_req,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             finished,
  output logic             timeout_err,
  output logic [NUM_W-1:0] req_count,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency
);

  state_t           r_state;
  state_t           w_nxt;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_cnt;
  logic [LAT_W-1:0] r_last;
  logic [LAT_W-1:0] r_max;
  logic             r_to;
  logic [LAT_W-1:0] w_lat;
  logic             w_tc;

  race_lat_counter #(
    .W     (LAT_W),
    .LIMIT (TIMEOUT)
  ) u_lat (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != ST_REQ),
    .i_en  ((r_state == ST_REQ) && !done),
    .o_lat (w_lat),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    start    = 1'b0;
    busy     = 1'b1;
    finished = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (go) begin
          w_nxt = (num_req != '0) ? ST_REQ : ST_FIN;
        end
      end
      ST_REQ: begin
        start = 1'b1;
        // done takes priority over a timeout landing on the same edge
        if (done) begin
          w_nxt = ST_GAP;
        end else if (w_tc) begin
          w_nxt = ST_FIN;
        end
      end
      ST_GAP: begin
        w_nxt = (r_cnt < r_num) ? ST_REQ : ST_FIN;
      end
      ST_FIN: begin
        finished = 1'b1;
        w_nxt    = ST_IDLE;
      end
      default: begin
        w_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num  <= '0;
      r_cnt  <= '0;
      r_last <= '0;
      r_max  <= '0;
      r_to   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && go) begin
        r_num  <= num_req;
        r_cnt  <= '0;
        r_last <= '0;
        r_max  <= '0;
        r_to   <= 1'b0;
      end
      if (r_state == ST_REQ) begin
        if (done) begin
          r_last <= w_lat;
          r_cnt  <= r_cnt + 1'b1;
          if (w_lat > r_max) begin
            r_max <= w_lat;
          end
        end else if (w_tc) begin
          r_to <= 1'b1;
        end
      end
    end
  end

  assign timeout_err  = r_to;
  assign req_count    = r_cnt;
  assign last_latency = r_last;
  assign max_latency  = r_max;

endmodule

// File: tb/tb_race_requester.sv
// Randomised batch bench for race_requester with a latency-list reference model.
module tb_race_requester;

  localparam int NUM_W = 8;
  localparam int LAT_W = 16;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             go = 1'b0;
  logic             done = 1'b0;
  logic [NUM_W-1:0] num_req = '0;
  logic             start;
  logic             busy;
  logic             finished;
  logic             timeout_err;
  logic [NUM_W-1:0] req_count;
  logic [LAT_W-1:0] last_latency;
  logic [LAT_W-1:0] max_latency;

  int n_total = 0;
  int n_bad   = 0;
  int lat_q[$];
  int e_cnt = 0;
  int e_max = 0;
  int e_last = 0;
  int e_to = 0;

  race_requester #(
    .NUM_W   (NUM_W),
    .LAT_W   (LAT_W),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .num_req      (num_req),
    .start        (start),
    .done         (done),
    .busy         (busy),
    .finished     (finished),
    .timeout_err  (timeout_err),
    .req_count    (req_count),
    .last_latency (last_latency),
    .max_latency  (max_latency)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check_eq({tag, "_req_count"}, 32'(req_count), e_cnt);
    check_eq({tag, "_max_lat"}, 32'(max_latency), e_max);
    check_eq({tag, "_last_lat"}, 32'(last_latency), e_last);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), e_to);
  endtask

  // Expected batch outcome: requests complete in order until the first one slower than TO.
  task automatic model_batch(input int n);
    e_cnt = 0; e_max = 0; e_last = 0; e_to = 0;
    for (int i = 0; i < n; i++) begin
      if (lat_q[i] > TO) begin
        e_to = 1;
        break;
      end
      e_cnt++;
      e_last = lat_q[i];
      if (lat_q[i] > e_max) e_max = lat_q[i];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the batch is back in IDLE.
  task automatic run_batch(input int n, input bit chaos);
    int hi;
    model_batch(n);
    go = 1'b1;
    num_req = NUM_W'(n);
    @(negedge clk);
    go = 1'b0;
    if (n == 0) begin
      check_eq("zero_finished", 32'(finished), 1);
      check_eq("zero_start", 32'(start), 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        int lat = lat_q[i];
        check_eq("start_up", 32'(start), 1);
        hi = 0;
        while (start && hi <= TO + 2) begin
          hi++;
          done = (lat <= TO) && (hi == lat);
          if (chaos && !done && $urandom_range(0, 2) == 0) begin
            go = 1'b1;
            num_req = NUM_W'($urandom);
          end
          @(negedge clk);
          done = 1'b0;
          go = 1'b0;
        end
        check_eq("start_width", hi, (lat <= TO) ? lat : TO);
        if (lat > TO) begin
          check_eq("to_finished", 32'(finished), 1);
          check_eq("to_start", 32'(start), 0);
          break;
        end
        check_eq("gap_last_lat", 32'(last_latency), lat);
        check_eq("gap_req_count", 32'(req_count), i + 1);
        check_eq("gap_start", 32'(start), 0);
        check_eq("gap_busy", 32'(busy), 1);
        if (chaos) done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check_eq("post_gap_req_count", 32'(req_count), i + 1);
        check_eq("post_gap_last_lat", 32'(last_latency), lat);
        if (i == n - 1) check_eq("finished", 32'(finished), 1);
      end
    end
    check_results("batch");
    @(negedge clk);
    check_eq("idle_finished", 32'(finished), 0);
    check_eq("idle_busy", 32'(busy), 0);
  endtask

  task automatic idle_done_check();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_eq("idle_done_start", 32'(start), 0);
    check_eq("idle_done_busy", 32'(busy), 0);
    check_eq("idle_done_finished", 32'(finished), 0);
    check_results("idle_done");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_results("reset");
    check_eq("reset_start", 32'(start), 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_finished", 32'(finished), 0);
    rst = 1'b1;
    @(negedge clk);
    idle_done_check();

    lat_q = '{3};
    run_batch(1, 1'b0);
    lat_q = '{1, 5, 2, 7};
    run_batch(4, 1'b0);
    lat_q = '{40};
    run_batch(1, 1'b0);
    idle_done_check();
    lat_q = '{};
    run_batch(0, 1'b0);
    lat_q = '{16, 2};
    run_batch(2, 1'b0);
    lat_q = '{2, 3, 4};
    run_batch(3, 1'b1);
    idle_done_check();

    // Reset in the middle of the second request of a two-request batch.
    go = 1'b1;
    num_req = NUM_W'(2);
    @(negedge clk);
    go = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_eq("pre_reset_req_count", 32'(req_count), 1);
    repeat (2) @(negedge clk);
    check_eq("pre_reset_start", 32'(start), 1);
    rst = 1'b0;
    #1;
    e_cnt = 0; e_max = 0; e_last = 0; e_to = 0;
    check_results("mid_reset");
    check_eq("mid_reset_start", 32'(start), 0);
    check_eq("mid_reset_busy", 32'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("mid_reset_finished", 32'(finished), 0);
    end
    rst = 1'b1;
    lat_q = '{3};
    run_batch(1, 1'b0);

    for (int b = 0; b < 25; b++) begin
      int n = $urandom_range(1, 5);
      lat_q = '{};
      for (int i = 0; i < n; i++) lat_q.push_back($urandom_range(1, 19));
      run_batch(n, 1'($urandom_range(0, 1)));
      if (b % 5 == 0) idle_done_check();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
